// File: rtl/fp_mul_arbiter_pkg.sv
// Shared float32 scheduling types and constants for the multiplier arbiter.
package fp_sched_pkg;

  localparam int unsigned FP_W = 32;

  typedef logic [FP_W-1:0] fp32_t;

  localparam fp32_t FP_ONE  = 32'h3f800000;
  localparam fp32_t FP_ZERO = 32'h00000000;

  // DRAIN flushes stale IP results after reset; RUN is normal operation.
  typedef enum logic {DRAIN, RUN} arb_state_t;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Requester-side bus of the shared float32 multiplier.
//   req_valid_in  : per-requester request valid
//   req_a_in/b_in : per-requester float32 operands
//   req_ready_out : one-hot grant (handshake = valid & ready)
//   res_valid_out : one-hot single-cycle result strobe
//   res_data_out  : shared float32 product bus
// master = requester side, slave = arbiter side.
interface fp_mul_arbiter_if
  import fp_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) ();

  logic  [N_REQ-1:0] req_valid_in;
  fp32_t [N_REQ-1:0] req_a_in;
  fp32_t [N_REQ-1:0] req_b_in;
  logic  [N_REQ-1:0] req_ready_out;
  logic  [N_REQ-1:0] res_valid_out;
  fp32_t             res_data_out;

  modport master (
    output req_valid_in, req_a_in, req_b_in,
    input  req_ready_out, res_valid_out, res_data_out
  );

  modport slave (
    input  req_valid_in, req_a_in, req_b_in,
    output req_ready_out, res_valid_out, res_data_out
  );

endinterface

// File: rtl/fp_mul_arbiter_tag_fifo.sv
// Synchronous tag FIFO tracking the requester id of each in-flight multiply.
//   clk_in/rst_in : clock, synchronous active-high reset
//   push/din      : write request and data
//   pop/dout      : read request and head-of-queue data (show-ahead)
//   full/empty    : occupancy flags
// Push and pop together are honoured when full; a pop while empty is ignored.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined float32 multiplier IP among N_REQ
// requesters. Issued requester ids are queued in a tag FIFO so each result
// returning from the fixed-latency IP is routed back to its issuer. After
// reset, LATENCY+1 cycles of DRAIN discard stale results from the unreset IP.
//   clk_in, rst_in : clock, synchronous active-high reset
//   req_bus        : requester handshake and result bus (slave side)
//   mul_a/b_out    : operands to the IP
//   mul_valid_out  : operand valid to the IP
//   mul_res_in     : product from the IP
//   mul_valid_in   : product valid from the IP
//   busy_out       : draining or any operation outstanding
module fp_mul_arbiter
  import fp_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LATENCY = 6,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  fp_mul_arbiter_if.slave  req_bus,
  output fp32_t            mul_a_out,
  output fp32_t            mul_b_out,
  output logic             mul_valid_out,
  input  fp32_t            mul_res_in,
  input  logic             mul_valid_in,
  output logic             busy_out
);

  typedef logic [$clog2(N_REQ)-1:0] req_id_t;

  localparam int unsigned CNT_W      = $clog2(LATENCY + 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LATENCY);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  req_id_t          ptr;
  req_id_t          winner;
  logic             found;
  logic [N_REQ-1:0] grant;
  logic             push;
  logic             pop;
  logic             block;
  logic             proto_drop;
  logic [N_REQ-1:0] res_onehot;

  req_id_t          fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  // ---------------- drain FSM ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= DRAIN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = DRAIN;
    endcase
  end

  // ---------------- return path ----------------
  assign pop        = mul_valid_in & (state == RUN) & ~fifo_empty;
  assign proto_drop = mul_valid_in & (state == RUN) & fifo_empty;

  // A pop this cycle frees a slot, so a full FIFO can still accept a push.
  assign block = fifo_full & ~pop;

  // ---------------- round-robin arbiter ----------------
  always_comb begin
    int unsigned idx;
    req_id_t     cand;
    grant  = '0;
    winner = ptr;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    if (state == RUN && !block) begin
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        idx  = (32'(ptr) + k) % N_REQ;
        cand = req_id_t'(idx);
        if (!found && req_bus.req_valid_in[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
      if (found) grant[winner] = 1'b1;
    end
  end

  assign req_bus.req_ready_out = grant;
  assign push = found;

  always_comb begin
    res_onehot = '0;
    res_onehot[fifo_dout] = pop;
  end

  // ---------------- issue and result registers ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mul_valid_out         <= 1'b0;
      mul_a_out             <= FP_ZERO;
      mul_b_out             <= FP_ZERO;
      ptr                   <= req_id_t'(N_REQ - 1);
      req_bus.res_valid_out <= '0;
      req_bus.res_data_out  <= FP_ZERO;
    end else begin
      mul_valid_out <= push;
      if (push) begin
        mul_a_out <= req_bus.req_a_in[winner];
        mul_b_out <= req_bus.req_b_in[winner];
        ptr       <= winner;
      end
      req_bus.res_valid_out <= res_onehot;
      if (pop) begin
        req_bus.res_data_out <= mul_res_in;
      end
    end
  end

  assign busy_out = (state == DRAIN) | ~fifo_empty | mul_valid_out;

  tag_fifo #(
    .WIDTH ($bits(req_id_t)),
    .DEPTH (MAX_OUT)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (push),
    .din    (winner),
    .pop    (pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // A result with no outstanding tag cannot be routed and is dropped.
  a_no_orphan_result: assert property (@(posedge clk_in) disable iff (rst_in) !proto_drop)
    else $warning("fp_mul_arbiter: multiplier result with no outstanding tag dropped");

endmodule

// File: tb/tb_fp_mul_arbiter.sv
module tb_fp_mul_arbiter;
  import fp_sched_pkg::*;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned LAT   = 6;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic  rst_in, rst2;
  fp32_t mul_a, mul_b, mul_res, mul_a2, mul_b2, mul_res2;
  logic  mul_v, mul_vin, busy, mul_v2, mul_vin2, busy2;
  logic  inj = 1'b0;

  fp_mul_arbiter_if #(.N_REQ(N_REQ)) bus ();
  fp_mul_arbiter_if #(.N_REQ(N_REQ)) bus2 ();

  fp_mul_arbiter #(.N_REQ(N_REQ), .LATENCY(LAT), .MAX_OUT(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_bus(bus),
    .mul_a_out(mul_a), .mul_b_out(mul_b), .mul_valid_out(mul_v),
    .mul_res_in(mul_res), .mul_valid_in(mul_vin), .busy_out(busy)
  );

  fp_mul_arbiter #(.N_REQ(N_REQ), .LATENCY(LAT), .MAX_OUT(2)) dut2 (
    .clk_in(clk_in), .rst_in(rst2), .req_bus(bus2),
    .mul_a_out(mul_a2), .mul_b_out(mul_b2), .mul_valid_out(mul_v2),
    .mul_res_in(mul_res2), .mul_valid_in(mul_vin2), .busy_out(busy2)
  );

  // Hand-computed float32 vectors: va * vb = vp.
  fp32_t va [8] = '{32'h3f800000, 32'h40000000, 32'h3fc00000, 32'h3f000000,
                    32'hc0000000, 32'h40400000, 32'h41200000, FP_ONE};
  fp32_t vb [8] = '{32'h40000000, 32'h40400000, 32'h3fc00000, 32'h41000000,
                    32'h40400000, 32'h40400000, 32'h3f000000, FP_ONE};
  fp32_t vp [8] = '{32'h40000000, 32'h40c00000, 32'h40100000, 32'h40800000,
                    32'hc0c00000, 32'h41100000, 32'h40a00000, FP_ONE};

  function automatic fp32_t prod(fp32_t a, fp32_t b);
    for (int i = 0; i < 8; i++) if (va[i] == a && vb[i] == b) return vp[i];
    return 32'hbad0bad0;
  endfunction

  // Multiplier IP models: fixed latency, no reset.
  logic [LAT-1:0] pv = '0, pv2 = '0;
  fp32_t pd [LAT];
  fp32_t pd2 [LAT];
  always @(posedge clk_in) begin
    pv     <= {pv[LAT-2:0], mul_v};
    pv2    <= {pv2[LAT-2:0], mul_v2};
    pd[0]  <= prod(mul_a, mul_b);
    pd2[0] <= prod(mul_a2, mul_b2);
    for (int i = 1; i < LAT; i++) begin
      pd[i]  <= pd[i-1];
      pd2[i] <= pd2[i-1];
    end
  end
  assign mul_vin  = pv[LAT-1] | inj;
  assign mul_res  = inj ? 32'hdeadbeef : pd[LAT-1];
  assign mul_vin2 = pv2[LAT-1];
  assign mul_res2 = pd2[LAT-1];

  int unsigned n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard for dut ----------------
  typedef struct {
    int unsigned id;
    fp32_t       data;
    int unsigned due;
  } exp_t;
  exp_t        sb[$];
  exp_t        e;
  int unsigned cyc = 0;
  logic        saw_drop = 1'b0;

  always @(negedge clk_in) begin
    cyc = cyc + 1;
    if (dut.proto_drop) saw_drop = 1'b1;
    if (rst_in) begin
      sb.delete();
    end else begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("res_route", 64'(bus.res_valid_out), 64'(1) << e.id);
        chk("res_data", 64'(bus.res_data_out), 64'(e.data));
      end else begin
        chk("res_idle", 64'(bus.res_valid_out), 64'd0);
      end
      chk("grant_onehot", 64'($countones(bus.req_ready_out) <= 1), 64'd1);
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_valid_in[i] && bus.req_ready_out[i])
          sb.push_back('{id: i, data: prod(bus.req_a_in[i], bus.req_b_in[i]), due: cyc + LAT + 2});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  int unsigned gl[$];
  int unsigned gc[$];

  task automatic run_idle(input int unsigned maxc);
    logic [N_REQ-1:0] g;
    int unsigned it;
    it = 0;
    while (bus.req_valid_in != '0 && it < maxc) begin
      @(negedge clk_in);
      g = bus.req_valid_in & bus.req_ready_out;
      for (int i = 0; i < N_REQ; i++) if (g[i]) begin
        gl.push_back(i);
        gc.push_back(it);
      end
      tick();
      bus.req_valid_in = bus.req_valid_in & ~g;
      it++;
    end
    chk("grant_timeout", 64'(bus.req_valid_in), 64'd0);
  endtask

  task automatic wait_sb();
    for (int k = 0; k < 100 && sb.size() != 0; k++) tick();
    chk("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  logic done2 = 1'b0;

  // ---------------- main sequence on dut ----------------
  initial begin
    int unsigned n;
    int unsigned ex;
    rst_in = 1'b1;
    bus.req_valid_in = '0;
    bus.req_a_in = '0;
    bus.req_b_in = '0;
    tick(); tick(); tick();

    chk("rst_ready", 64'(bus.req_ready_out), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid_out), 64'd0);
    chk("rst_res_data", 64'(bus.res_data_out), 64'd0);
    chk("rst_mul_valid", 64'(mul_v), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);

    // Request straight out of reset must wait out the drain.
    bus.req_a_in[0] = va[0];
    bus.req_b_in[0] = vb[0];
    bus.req_valid_in = 4'b0001;
    rst_in = 1'b0;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_in);
      if (bus.req_ready_out[0]) break;
      n++;
    end
    chk("drain_len", 64'(n), 64'(LAT + 1));
    tick();
    bus.req_valid_in = '0;
    wait_sb();
    chk("busy_idle", 64'(busy), 64'd0);

    // Three simultaneous requesters: grants 0,1,2 back to back.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.req_a_in[i] = va[i+1];
      bus.req_b_in[i] = vb[i+1];
    end
    bus.req_valid_in = 4'b0111;
    gl.delete(); gc.delete();
    run_idle(40);
    chk("grp_count", 64'(gl.size()), 64'd3);
    chk("grp_order0", 64'(gl[0]), 64'd0);
    chk("grp_order1", 64'(gl[1]), 64'd1);
    chk("grp_order2", 64'(gl[2]), 64'd2);
    chk("grp_consec", 64'(gc[2] - gc[0]), 64'd2);
    wait_sb();

    // All four continuously valid: one grant per cycle, wrapping.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_a_in[i] = va[i+4];
      bus.req_b_in[i] = vb[i+4];
    end
    bus.req_valid_in = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (bus.req_ready_out != '0) break;
    end
    ex = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk_in);
      chk("rr_grant", 64'(bus.req_ready_out), 64'(1) << ex);
      ex = (ex + 1) % N_REQ;
    end
    tick();
    bus.req_valid_in = '0;
    wait_sb();

    // Reset with operations in flight: stale results must be discarded.
    for (int i = 0; i < 3; i++) begin
      bus.req_a_in[i] = va[i+5];
      bus.req_b_in[i] = vb[i+5];
    end
    bus.req_valid_in = 4'b0111;
    gl.delete(); gc.delete();
    run_idle(20);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    bus.req_a_in[3] = va[0];
    bus.req_b_in[3] = vb[0];
    bus.req_valid_in = 4'b1000;
    gl.delete(); gc.delete();
    run_idle(40);
    chk("post_rst_grant", 64'(gl[0]), 64'd3);
    wait_sb();

    // Orphan result with empty FIFO: dropped and flagged.
    saw_drop = 1'b0;
    inj = 1'b1;
    tick();
    inj = 1'b0;
    tick(); tick(); tick();
    chk("orphan_flag", 64'(saw_drop), 64'd1);
    chk("orphan_sb", 64'(sb.size()), 64'd0);

    for (int k = 0; k < 300 && !done2; k++) tick();
    chk("dut2_done", 64'(done2), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- MAX_OUT=2 sequence on dut2 ----------------
  initial begin
    int unsigned c2, rcnt;
    int unsigned gcyc[$];
    logic        popat[$];
    rst2 = 1'b1;
    bus2.req_valid_in = '0;
    bus2.req_a_in = '0;
    bus2.req_b_in = '0;
    tick(); tick(); tick();
    rst2 = 1'b0;
    bus2.req_a_in[1] = va[2];
    bus2.req_b_in[1] = vb[2];
    bus2.req_valid_in = 4'b0010;
    c2 = 0;
    rcnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_in);
      c2++;
      if (bus2.req_valid_in[1] && bus2.req_ready_out[1]) begin
        gcyc.push_back(c2);
        popat.push_back(mul_vin2);
      end
      if (bus2.res_valid_out != '0) begin
        rcnt++;
        chk("full_route", 64'(bus2.res_valid_out), 64'd2);
        chk("full_data", 64'(bus2.res_data_out), 64'(vp[2]));
      end
      if (k == 39) begin
        tick();
        bus2.req_valid_in = '0;
      end
    end
    chk("full_ngrants", 64'(gcyc.size() >= 4), 64'd1);
    chk("full_gap01", 64'(gcyc[1] - gcyc[0]), 64'd1);
    chk("full_gap12", 64'(gcyc[2] - gcyc[1]), 64'(LAT));
    chk("full_pop_grant", 64'(popat[2]), 64'd1);
    chk("full_gap23", 64'(gcyc[3] - gcyc[2]), 64'd1);
    chk("full_results", 64'(rcnt), 64'(gcyc.size()));
    done2 = 1'b1;
  end

endmodule
